// File: rtl/banked_frame_buffer_if.sv
// Memory-port bundle for banked_frame_buffer: request/ready handshake with a
// pipelined read response (rvalid/rdata/err).
interface banked_frame_buffer_if #(
   parameter int ADDR_W = 19,
   parameter int PIX_W  = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_wdata;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [PIX_W-1:0]  mem_rdata;
   logic              mem_err;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_ready, mem_rvalid, mem_rdata, mem_err);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_ready, mem_rvalid, mem_rdata, mem_err);
endinterface

// File: rtl/banked_frame_buffer.sv
// Banked frame buffer: raster display read port plus a handshaked memory port.
// Define FB_CLEAR_EN to build the whole-frame hardware clear engine.
module banked_frame_buffer #(
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int PIX_W      = 8,
   parameter int BANK_DEPTH = 65536,
   parameter int ADDR_W     = 19
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 disp_en,
   input  logic [9:0]           hcount,
   input  logic [9:0]           vcount,
   output logic [PIX_W-1:0]     pixel,
   output logic                 pixel_valid,
   banked_frame_buffer_if.slave mem,
   input  logic                 clear_start,
   input  logic [PIX_W-1:0]     clear_value,
   output logic                 clear_busy,
   output logic                 clear_done
);
   localparam int FRAME     = WIDTH * HEIGHT;
   localparam int NUM_BANKS = (FRAME + BANK_DEPTH - 1) / BANK_DEPTH;
   localparam int OFF_W     = $clog2(BANK_DEPTH);
   localparam int BANK_W    = ADDR_W - OFF_W;

   typedef struct packed {
      logic              rd;
      logic              err;
      logic [BANK_W-1:0] bank;
   } req_stage_t;

   typedef struct packed {
      logic             rd;
      logic             err;
      logic [PIX_W-1:0] data;
   } rsp_stage_t;

   logic [OFF_W-1:0] clr_cnt;
   logic [PIX_W-1:0] clr_val;
   logic             clr_active;

`ifdef FB_CLEAR_EN
   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;
   state_t state, state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (clear_start) state_nxt = S_CLEAR;
         S_CLEAR: if (clr_cnt == OFF_W'(BANK_DEPTH - 1)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      clr_active    = (state == S_CLEAR);
      clear_busy    = (state == S_CLEAR);
      clear_done    = (state == S_DONE);
      mem.mem_ready = (state == S_IDLE);
   end

   // Offset walks all banks in lockstep; fill value is captured at start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt <= '0;
         clr_val <= '0;
      end else if (state == S_IDLE && clear_start) begin
         clr_cnt <= '0;
         clr_val <= clear_value;
      end else if (state == S_CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end
`else
   logic unused_clear;
   assign unused_clear  = ^{clear_start, clear_value};
   assign clr_active    = 1'b0;
   assign clr_cnt       = '0;
   assign clr_val       = '0;
   assign clear_busy    = 1'b0;
   assign clear_done    = 1'b0;
   assign mem.mem_ready = 1'b1;
`endif

   logic              acc;
   logic              m_in;
   logic [OFF_W-1:0]  m_off;
   logic [BANK_W-1:0] m_bank;
   logic [ADDR_W-1:0] d_addr;
   logic              d_hit;

   assign acc    = mem.mem_req && mem.mem_ready;
   assign m_off  = mem.mem_addr[OFF_W-1:0];
   assign m_bank = mem.mem_addr[ADDR_W-1:OFF_W];
   assign m_in   = {1'b0, mem.mem_addr} < (ADDR_W+1)'(FRAME);
   assign d_addr = ADDR_W'(vcount) * ADDR_W'(WIDTH) + ADDR_W'(hcount);
   assign d_hit  = disp_en && (32'(hcount) < WIDTH) && (32'(vcount) < HEIGHT);

   logic [NUM_BANKS-1:0][PIX_W-1:0] d_q;
   logic [NUM_BANKS-1:0][PIX_W-1:0] m_q;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      localparam int LIM = FRAME - b * BANK_DEPTH;
      logic [PIX_W-1:0] ram [BANK_DEPTH];
      logic             we;
      logic [OFF_W-1:0] waddr;
      logic [PIX_W-1:0] wdata;
      logic [PIX_W-1:0] d_rd;
      logic [PIX_W-1:0] m_rd;

      // The memory port is held off while clearing, so the two writers never collide
      always_comb begin
         if (clr_active) begin
            we    = 32'(clr_cnt) < LIM;
            waddr = clr_cnt;
            wdata = clr_val;
         end else begin
            we    = acc && mem.mem_we && m_in && (m_bank == BANK_W'(b));
            waddr = m_off;
            wdata = mem.mem_wdata;
         end
      end

      // Reads sample the pre-write contents on a same-edge collision
      always_ff @(posedge clk) begin
         if (we) ram[waddr] <= wdata;
         d_rd <= ram[d_addr[OFF_W-1:0]];
         m_rd <= ram[m_off];
      end

      assign d_q[b] = d_rd;
      assign m_q[b] = m_rd;
   end

   function automatic logic [PIX_W-1:0] pick(input logic [NUM_BANKS-1:0][PIX_W-1:0] q,
                                             input logic [BANK_W-1:0] sel);
      pick = '0;
      for (int i = 0; i < NUM_BANKS; i++)
         if (sel == BANK_W'(i)) pick = q[i];
   endfunction

   logic              d1_hit;
   logic [BANK_W-1:0] d1_bank;
   logic              d2_hit;
   logic [PIX_W-1:0]  d2_pix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1_hit      <= 1'b0;
         d1_bank     <= '0;
         d2_hit      <= 1'b0;
         d2_pix      <= '0;
         pixel       <= '0;
         pixel_valid <= 1'b0;
      end else begin
         d1_hit      <= d_hit;
         d1_bank     <= d_addr[ADDR_W-1:OFF_W];
         d2_hit      <= d1_hit;
         d2_pix      <= d1_hit ? pick(d_q, d1_bank) : {PIX_W{1'b0}};
         pixel       <= d2_pix;
         pixel_valid <= d2_hit;
      end
   end

   req_stage_t m1;
   rsp_stage_t m2;

   // Out-of-range writes travel down the same pipe so their err lines up with reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1             <= '0;
         m2             <= '0;
         mem.mem_rvalid <= 1'b0;
         mem.mem_err    <= 1'b0;
         mem.mem_rdata  <= '0;
      end else begin
         m1             <= '{rd: acc && !mem.mem_we, err: acc && !m_in, bank: m_bank};
         m2             <= '{rd: m1.rd, err: m1.err,
                             data: m1.err ? {PIX_W{1'b0}} : pick(m_q, m1.bank)};
         mem.mem_rvalid <= m2.rd;
         mem.mem_err    <= m2.err;
         if (m2.rd) mem.mem_rdata <= m2.data;
      end
   end
endmodule
